// File: rtl/io1in_pkg.sv
// Shared types and constants for the io1in pad-input debounce slice.
package io1in_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/io1in_sync.sv
// Multi-flop synchronizer bringing the asynchronous pad level into real_clk.
module io1in_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic real_clk,
  input  logic real_rst,
  input  logic async_level,
  output logic sync_level
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) chain <= {STAGES{INIT}};
    else          chain <= {chain[STAGES-2:0], async_level};
  end

  assign sync_level = chain[STAGES-1];

endmodule

// File: rtl/io1in_debounce.sv
// Pad input consumer: synchronizer, counter debouncer, edge pulses and a one-entry event register.
// Build option IO1IN_GLITCH_CNT_EN enables the saturating rejected-glitch counter.
//
//   state    | meaning
//   STABLE   | synchronized input matches level_out, counter idle
//   COUNTING | input differs from level_out, counting consecutive samples
module io1in_debounce
  import io1in_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 16,
  parameter int   CNT_W       = 8,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic                real_clk,
  input  logic                real_rst,
  input  logic                pin_in,
  output logic                level_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                evt_edge,
  output logic                evt_overflow,
  input  logic                ovf_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_q;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             reject;
  logic             pulse;

  io1in_sync #(
    .STAGES (SYNC_STAGES),
    .INIT   (INIT_LEVEL)
  ) u_sync (
    .real_clk    (real_clk),
    .real_rst    (real_rst),
    .async_level (pin_in),
    .sync_level  (sync_q)
  );

  assign reject = (state == COUNTING) && (sync_q == level_out);
  assign pulse  = rise_pulse | fall_pulse;

  // Accepting a change copies sync_q, which is the new level since it differs from level_out.
  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) begin
      state      <= STABLE;
      cnt        <= '0;
      level_out  <= INIT_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        STABLE: begin
          cnt <= '0;
          if (sync_q != level_out) begin
            if (DB_CYCLES == 1) begin
              level_out  <= sync_q;
              rise_pulse <= sync_q;
              fall_pulse <= ~sync_q;
            end else begin
              state <= COUNTING;
              cnt   <= CNT_ONE;
            end
          end
        end
        COUNTING: begin
          if (reject) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            level_out  <= sync_q;
            rise_pulse <= sync_q;
            fall_pulse <= ~sync_q;
            state      <= STABLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A pulse coinciding with a handshake replaces the old event without a bubble.
  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) begin
      evt_valid    <= 1'b0;
      evt_edge     <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      if (pulse && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_edge  <= rise_pulse ? EDGE_RISE : EDGE_FALL;
      end else if (!pulse && evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (pulse && evt_valid && !evt_ready) evt_overflow <= 1'b1;
      else if (ovf_clr)                     evt_overflow <= 1'b0;
    end
  end

`ifdef IO1IN_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q;

  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst)                      glitch_q <= '0;
    else if (reject && glitch_q != '1) glitch_q <= glitch_q + GLITCH_W'(1);
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule
